// File: rtl/sysu_key_pkg.sv
// Shared types and constants for the key event decoder.
package sysu_key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } key_state_e;

    localparam int CNT_W  = 16;
    localparam int CNT_W1 = CNT_W + 1;

    localparam int DEF_TICK_DIV     = 100000;
    localparam int DEF_LONG_TICKS   = 1000;
    localparam int DEF_REPEAT_TICKS = 200;
    localparam bit DEF_ACTIVE_LOW   = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sysu_tick_gen.sv
// Hold-time prescaler: one-cycle tick every DIV cycles, restartable by clr.
module sysu_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk100Mhz,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A restart in the same cycle suppresses the terminal tick.
    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/sysu_key_event.sv
// Turns the debounced key level into press/release/long/repeat pulses,
// a held flag and a wrapping press counter.
//   state   | meaning
//   IDLE    | key released, waiting for a press edge
//   PRESSED | key down, counting ticks towards long-press
//   LONG    | long-press reached, emitting auto-repeat pulses
module sysu_key_event
    import sysu_key_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
    input  logic       clk100Mhz,
    input  logic       rst,
    input  logic       button_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       key_held,
    output logic [7:0] press_count
);
    localparam logic [CNT_W1-1:0] LONG_CMP = CNT_W1'(LONG_TICKS);
    localparam logic [CNT_W1-1:0] RPT_CMP  = CNT_W1'(REPEAT_TICKS);

    logic btn_pressed;
    logic sync1_q, sync2_q, edge_q;
    logic rise, fall, tick;

    key_state_e state_q, state_d;
    logic [CNT_W-1:0]  hold_q, hold_d, rpt_q, rpt_d;
    logic [CNT_W1-1:0] hold_inc, rpt_inc;
    logic [7:0]        cnt_q, cnt_d;
    logic press_q, press_d, release_q, release_d;
    logic long_q, long_d, repeat_q, repeat_d;
    logic long_hit, rpt_hit;

    assign btn_pressed = ACTIVE_LOW ? ~button_in : button_in;

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= btn_pressed;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~edge_q;
    assign fall = ~sync2_q & edge_q;

    sysu_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk100Mhz (clk100Mhz),
        .rst       (rst),
        .clr       (rise),
        .tick      (tick)
    );

    assign hold_inc = {1'b0, hold_q} + CNT_W1'(1);
    assign rpt_inc  = {1'b0, rpt_q} + CNT_W1'(1);
    assign long_hit = tick && (hold_inc == LONG_CMP);
    assign rpt_hit  = tick && (rpt_inc == RPT_CMP);

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Release edge outranks a coincident tick in every held state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rise) state_d = PRESSED;
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (long_hit) begin
                    state_d = LONG;
                end
            end
            LONG:    if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        rpt_d     = rpt_q;
        if ((state_q != IDLE) && tick) begin
            hold_d = sat_inc(hold_q);
        end
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                end else if (long_hit) begin
                    long_d = 1'b1;
                    rpt_d  = '0;
                end
            end
            LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                end else if (rpt_hit) begin
                    repeat_d = 1'b1;
                    rpt_d    = '0;
                end else if (tick) begin
                    rpt_d = rpt_inc[CNT_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            rpt_q     <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            rpt_q     <= rpt_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign key_held      = edge_q;
    assign press_count   = cnt_q;

endmodule
